// File: rtl/mic1_microsequencer_if.sv
// Signal bundle between the MIC-1 microsequencer, its control store and the datapath.
// The master modport is the sequencer side. The slave modport is the store/datapath side.
interface mic1_microsequencer_if;
  logic [8:0]  cs_addr;
  logic [35:0] cs_data;
  logic        alu_n;
  logic        alu_z;
  logic [7:0]  mbr;
  logic        mem_done;
  logic        f0;
  logic        f1;
  logic        ena;
  logic        enb;
  logic        inva;
  logic        inc;
  logic        sll8;
  logic        sra1;
  logic [8:0]  c_en;
  logic [3:0]  b_sel;
  logic        mem_write;
  logic        mem_read;
  logic        mem_fetch;
  logic [8:0]  mpc;
  logic        halted;

  modport master (
    output cs_addr, f0, f1, ena, enb, inva, inc, sll8, sra1, c_en, b_sel,
           mem_write, mem_read, mem_fetch, mpc, halted,
    input  cs_data, alu_n, alu_z, mbr, mem_done
  );

  modport slave (
    input  cs_addr, f0, f1, ena, enb, inva, inc, sll8, sra1, c_en, b_sel,
           mem_write, mem_read, mem_fetch, mpc, halted,
    output cs_data, alu_n, alu_z, mbr, mem_done
  );
endinterface

// File: rtl/mic1_microsequencer.sv
// MIC-1 microsequencer: holds MPC and MIR, and fetches from a combinational control store.
// It decodes datapath controls in EXEC and forms the next address from the JAM/JMPC bits.
module mic1_microsequencer #(
  parameter logic [8:0] RESET_ADDR = 9'h000,
  parameter logic [8:0] HALT_ADDR  = 9'h1FF
) (
  input logic                  clk,
  input logic                  rst_n,
  mic1_microsequencer_if.master bus
);
  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_MWAIT = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]  state;
  logic [35:0] mir;
  logic [8:0]  mpc_q;
  logic        n_q;
  logic        z_q;
  logic [7:0]  mbr_q;
  logic [8:0]  next_addr;
  logic        exec;

  // Next-address generation is a pure OR, so JMPC never carries into NEXT_ADDR bits.
  always_comb begin
    next_addr = mir[35:27]
              | (mir[26] ? {1'b0, mbr_q} : 9'h000)
              | {((mir[25] & n_q) | (mir[24] & z_q)), 8'h00};
  end

  always_comb begin
    case (state)
      S_INIT:  bus.cs_addr = RESET_ADDR;
      S_FETCH: bus.cs_addr = next_addr;
      default: bus.cs_addr = mpc_q;
    endcase
  end

  assign exec          = (state == S_EXEC);
  assign bus.sll8      = exec & mir[23];
  assign bus.sra1      = exec & mir[22];
  assign bus.f0        = exec & mir[21];
  assign bus.f1        = exec & mir[20];
  assign bus.ena       = exec & mir[19];
  assign bus.enb       = exec & mir[18];
  assign bus.inva      = exec & mir[17];
  assign bus.inc       = exec & mir[16];
  assign bus.c_en      = exec ? mir[15:7] : 9'h000;
  assign bus.mem_write = exec & mir[6];
  assign bus.mem_read  = exec & mir[5];
  assign bus.mem_fetch = exec & mir[4];
  assign bus.b_sel     = exec ? mir[3:0] : 4'h0;
  assign bus.mpc       = mpc_q;
  assign bus.halted    = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      mir   <= 36'h0;
      mpc_q <= RESET_ADDR;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      mbr_q <= 8'h00;
    end else begin
      case (state)
        S_INIT: begin
          mir   <= bus.cs_data;
          mpc_q <= RESET_ADDR;
          state <= (RESET_ADDR == HALT_ADDR) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          n_q <= bus.alu_n;
          z_q <= bus.alu_z;
          if (mir[6:4] != 3'b000) begin
            state <= S_MWAIT;
          end else begin
            mbr_q <= bus.mbr;
            state <= S_FETCH;
          end
        end
        S_MWAIT: begin
          if (bus.mem_done) begin
            mbr_q <= bus.mbr;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          mpc_q <= next_addr;
          mir   <= bus.cs_data;
          state <= (next_addr == HALT_ADDR) ? S_HALT : S_EXEC;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_mic1_microsequencer.sv
// Directed bench for mic1_microsequencer. A control-store array is read through cs_addr.
// Every control output is compared against hand-computed expected words.
module tb_mic1_microsequencer;
  logic        clk;
  logic        rst_n;
  logic [35:0] cs_mem [0:511];
  int          checks;
  int          passes;

  mic1_microsequencer_if bus ();

  mic1_microsequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.cs_data = cs_mem[bus.cs_addr];

  // Packed view of all EXEC-only outputs: {f0,f1,ena,enb,inva,inc,sll8,sra1,c_en,b_sel,w,r,f}
  wire [23:0] ctrl = {bus.f0, bus.f1, bus.ena, bus.enb, bus.inva, bus.inc, bus.sll8, bus.sra1,
                      bus.c_en, bus.b_sel, bus.mem_write, bus.mem_read, bus.mem_fetch};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // alu bits are {sll8,sra1,f0,f1,ena,enb,inva,inc}; jam bits are {jmpc,jamn,jamz}
  function automatic logic [35:0] uword(input logic [8:0] next, input logic [2:0] jam,
                                        input logic [7:0] alu, input logic [8:0] c,
                                        input logic [2:0] mem, input logic [3:0] b);
    return {next, jam, alu, c, mem, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cs();
    for (int i = 0; i < 512; i++) cs_mem[i] = 36'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_cs();
    cs_mem[0] = uword(9'h005, 3'b000, 8'b0011_1100, 9'h100, 3'b000, 4'h0);
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    checks++; if (ctrl !== 24'h0) $display("FAIL reset_ctrl: got %h expected %h", ctrl, 24'h0); else passes++;
    checks++; if (bus.halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", bus.halted); else passes++;
    checks++; if (bus.mpc !== 9'h000) $display("FAIL reset_mpc: got %h expected 000", bus.mpc); else passes++;
    checks++; if (bus.cs_addr !== 9'h000) $display("FAIL reset_cs_addr: got %h expected 000", bus.cs_addr); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ctrl !== 24'h0) $display("FAIL init_ctrl: got %h expected %h", ctrl, 24'h0); else passes++;
  endtask

  task automatic test_alu_decode();
    clear_cs();
    cs_mem[0] = uword(9'h005, 3'b000, 8'b0011_1100, 9'h100, 3'b000, 4'h0);
    bus.mem_done = 1'b0;
    do_reset();
    tick();
    checks++; if (ctrl !== {6'b111100, 2'b00, 9'h100, 4'h0, 3'b000})
      $display("FAIL decode_exec_ctrl: got %h expected %h", ctrl, {6'b111100, 2'b00, 9'h100, 4'h0, 3'b000}); else passes++;
    checks++; if (bus.mpc !== 9'h000) $display("FAIL decode_exec_mpc: got %h expected 000", bus.mpc); else passes++;
    tick();
    checks++; if (bus.cs_addr !== 9'h005) $display("FAIL decode_fetch_addr: got %h expected 005", bus.cs_addr); else passes++;
    checks++; if (ctrl !== 24'h0) $display("FAIL decode_fetch_ctrl: got %h expected 0", ctrl); else passes++;
    tick();
    checks++; if (bus.mpc !== 9'h005) $display("FAIL decode_next_mpc: got %h expected 005", bus.mpc); else passes++;
  endtask

  task automatic run_branch(input string name, input logic [8:0] next, input logic [2:0] jam,
                            input logic n, input logic z, input logic [7:0] mbr_exec,
                            input logic [9:0] dummy, input logic [8:0] expected);
    clear_cs();
    cs_mem[0] = uword(next, jam, 8'h00, 9'h000, 3'b000, 4'h0);
    bus.mem_done = 1'b0;
    bus.alu_n = 1'b0;
    bus.alu_z = 1'b0;
    bus.mbr = 8'h00;
    do_reset();
    tick();
    bus.alu_n = n;
    bus.alu_z = z;
    bus.mbr = mbr_exec;
    tick();
    bus.alu_n = ~n;
    bus.alu_z = ~z;
    bus.mbr = dummy[7:0];
    #1;
    checks++; if (bus.cs_addr !== expected) $display("FAIL %s_cs_addr: got %h expected %h", name, bus.cs_addr, expected); else passes++;
    tick();
    checks++; if (bus.mpc !== expected) $display("FAIL %s_mpc: got %h expected %h", name, bus.mpc, expected); else passes++;
  endtask

  task automatic test_jam();
    run_branch("jamz_taken", 9'h010, 3'b001, 1'b0, 1'b1, 8'h00, 10'h055, 9'h110);
    run_branch("jamz_not",   9'h010, 3'b001, 1'b1, 1'b0, 8'h00, 10'h055, 9'h010);
    run_branch("jamn_taken", 9'h010, 3'b010, 1'b1, 1'b0, 8'h00, 10'h055, 9'h110);
    run_branch("jamn_not",   9'h010, 3'b010, 1'b0, 1'b1, 8'h00, 10'h055, 9'h010);
    run_branch("jam_hi_set", 9'h110, 3'b001, 1'b0, 1'b1, 8'h00, 10'h055, 9'h110);
  endtask

  task automatic test_jmpc();
    run_branch("jmpc_lo",  9'h000, 3'b100, 1'b0, 1'b0, 8'hA7, 10'h055, 9'h0A7);
    run_branch("jmpc_hi",  9'h100, 3'b100, 1'b0, 1'b0, 8'hA7, 10'h055, 9'h1A7);
    run_branch("jmpc_or",  9'h081, 3'b100, 1'b0, 1'b0, 8'h81, 10'h055, 9'h081);
    run_branch("no_jmpc",  9'h020, 3'b000, 1'b0, 1'b0, 8'hA7, 10'h055, 9'h020);
  endtask

  task automatic test_mem_wait();
    clear_cs();
    cs_mem[0] = uword(9'h020, 3'b000, 8'h00, 9'h000, 3'b010, 4'h0);
    bus.mem_done = 1'b1;
    bus.mbr = 8'h00;
    do_reset();
    tick();
    checks++; if (bus.mem_read !== 1'b1) $display("FAIL mem_read_pulse: got %b expected 1", bus.mem_read); else passes++;
    tick();
    bus.mem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ctrl !== 24'h0) $display("FAIL mwait_ctrl_%0d: got %h expected 0", i, ctrl); else passes++;
      checks++; if (bus.cs_addr !== 9'h000) $display("FAIL mwait_addr_%0d: got %h expected 000", i, bus.cs_addr); else passes++;
      if (i < 2) tick();
    end
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    checks++; if (bus.cs_addr !== 9'h020) $display("FAIL mem_fetch_addr: got %h expected 020", bus.cs_addr); else passes++;
    checks++; if (bus.mem_read !== 1'b0) $display("FAIL mem_no_repulse: got %b expected 0", bus.mem_read); else passes++;
    tick();
    checks++; if (bus.mpc !== 9'h020) $display("FAIL mem_next_mpc: got %h expected 020", bus.mpc); else passes++;
  endtask

  task automatic test_back_to_back();
    clear_cs();
    cs_mem[0] = uword(9'h002, 3'b000, 8'b1100_0011, 9'h001, 3'b101, 4'h7);
    cs_mem[2] = uword(9'h003, 3'b000, 8'b0001_0100, 9'h040, 3'b000, 4'h2);
    bus.mem_done = 1'b1;
    do_reset();
    tick();
    checks++; if (ctrl !== {6'b000011, 2'b11, 9'h001, 4'h7, 3'b101})
      $display("FAIL b2b_exec0: got %h expected %h", ctrl, {6'b000011, 2'b11, 9'h001, 4'h7, 3'b101}); else passes++;
    tick();
    checks++; if (ctrl !== 24'h0) $display("FAIL b2b_mwait: got %h expected 0", ctrl); else passes++;
    tick();
    checks++; if (bus.cs_addr !== 9'h002) $display("FAIL b2b_fetch0: got %h expected 002", bus.cs_addr); else passes++;
    tick();
    checks++; if (ctrl !== {6'b010100, 2'b00, 9'h040, 4'h2, 3'b000})
      $display("FAIL b2b_exec2: got %h expected %h", ctrl, {6'b010100, 2'b00, 9'h040, 4'h2, 3'b000}); else passes++;
    tick();
    checks++; if (bus.cs_addr !== 9'h003) $display("FAIL b2b_fetch2: got %h expected 003", bus.cs_addr); else passes++;
    tick();
    checks++; if (bus.mpc !== 9'h003) $display("FAIL b2b_mpc3: got %h expected 003", bus.mpc); else passes++;
    bus.mem_done = 1'b0;
  endtask

  task automatic test_halt();
    clear_cs();
    cs_mem[0]      = uword(9'h1FF, 3'b000, 8'h3C, 9'h100, 3'b000, 4'h1);
    cs_mem[9'h1FF] = uword(9'h000, 3'b000, 8'hFF, 9'h1FF, 3'b111, 4'hF);
    do_reset();
    tick();
    tick();
    checks++; if (bus.cs_addr !== 9'h1FF) $display("FAIL halt_fetch_addr: got %h expected 1ff", bus.cs_addr); else passes++;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (bus.halted !== 1'b1) $display("FAIL halt_flag_%0d: got %b expected 1", i, bus.halted); else passes++;
      checks++; if (ctrl !== 24'h0) $display("FAIL halt_ctrl_%0d: got %h expected 0", i, ctrl); else passes++;
      checks++; if (bus.mpc !== 9'h1FF) $display("FAIL halt_mpc_%0d: got %h expected 1ff", i, bus.mpc); else passes++;
    end
  endtask

  task automatic test_reset_in_mwait();
    clear_cs();
    cs_mem[0]     = uword(9'h040, 3'b000, 8'h00, 9'h000, 3'b000, 4'h0);
    cs_mem[9'h40] = uword(9'h030, 3'b000, 8'h00, 9'h0AA, 3'b001, 4'h3);
    bus.mem_done = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    checks++; if (ctrl !== {6'b000000, 2'b00, 9'h0AA, 4'h3, 3'b001})
      $display("FAIL rmw_exec40: got %h expected %h", ctrl, {6'b000000, 2'b00, 9'h0AA, 4'h3, 3'b001}); else passes++;
    tick();
    checks++; if (bus.mpc !== 9'h040) $display("FAIL rmw_mwait_mpc: got %h expected 040", bus.mpc); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mpc !== 9'h000) $display("FAIL rmw_async_mpc: got %h expected 000", bus.mpc); else passes++;
    checks++; if (bus.cs_addr !== 9'h000) $display("FAIL rmw_async_addr: got %h expected 000", bus.cs_addr); else passes++;
    checks++; if ({ctrl, bus.halted} !== 25'h0) $display("FAIL rmw_async_ctrl: got %h expected 0", {ctrl, bus.halted}); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (bus.mpc !== 9'h000) $display("FAIL rmw_restart_mpc: got %h expected 000", bus.mpc); else passes++;
    tick();
    checks++; if (bus.cs_addr !== 9'h040) $display("FAIL rmw_restart_fetch: got %h expected 040", bus.cs_addr); else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n = 1'b1;
    bus.alu_n = 1'b0;
    bus.alu_z = 1'b0;
    bus.mbr = 8'h00;
    bus.mem_done = 1'b0;
    test_reset();
    test_alu_decode();
    test_jam();
    test_jmpc();
    test_mem_wait();
    test_back_to_back();
    test_halt();
    test_reset_in_mwait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
